mmul_tile_sched: RTL and testbench
==================================

# mmul_tile_sched

Tile-level scheduler for the N×N systolic matrix multiplier. It sits between the AXI-stream input adapter, the array and the AXI-stream output adapter. For each `start` it sequences one tile:
- accept N weight rows and N activation rows from the input buffer handshake;
- flush the array pipeline;
- drain N result rows to the output adapter under its backpressure.

It owns all array enables, so no tile beat is lost, overwritten or duplicated.

## Interface
Parameters:
- `N`, 4: array dimension; rows per operand and per result. N ≥ 1.
- `FLUSH_CYC`, 2*N-1: array drain latency in cycles after the last activation row.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; forces IDLE and all outputs to reset values immediately.
- `start`  in  1  begin one tile; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE; reset 0.
- `done`  out  1  one-cycle pulse after the last result row is accepted; reset 0.
- `inbuf_valid`  in  1  input adapter holds a valid row.
- `inbuf_ready`  out  1  scheduler consumes the row this cycle; reset 0.
- `w_load`  out  1  load the current row into weight row `row_idx`; reset 0.
- `a_feed`  out  1  push the current row into the activation skew; reset 0.
- `a_zero`  out  1  push zeros into the skew (flush bubble); reset 0.
- `array_en`  out  1  advance the systolic array one step; reset 0.
- `row_idx`  out  clog2(N) (min 1)  current row index in LOAD/STREAM/DRAIN; reset 0.
- `out_buff_enabled`  out  1  result row `row_idx` presented to the output adapter; reset 0.
- `out_buff_enable_feedback`  in  1  output adapter can accept this cycle.

## Operation
- FSM states: IDLE, LOAD, STREAM, FLUSH, DRAIN, DONE.
- IDLE: if `start`=1, go to LOAD. Otherwise stay.
- LOAD:
  - `inbuf_ready`=1.
  - On beat (`inbuf_valid`&`inbuf_ready`): `w_load`=1, `row_idx`++.
  - On beat with `row_idx`=N-1: `row_idx`←0 and go to STREAM.
- STREAM:
  - `inbuf_ready`=1.
  - On beat: `a_feed`=1, `array_en`=1, `row_idx`++.
  - No beat: `array_en`=0, so the array holds.
  - On the beat with `row_idx`=N-1: go to FLUSH and load the flush counter with FLUSH_CYC.
- FLUSH:
  - `a_zero`=1 and `array_en`=1 every cycle; counter decrements.
  - When the counter reaches 1: `row_idx`←0 and go to DRAIN.
- DRAIN:
  - `out_buff_enabled`=1.
  - When `out_buff_enable_feedback`=1: row accepted, `row_idx`++.
  - Accept with `row_idx`=N-1: go to DONE.
  - Feedback low: hold `row_idx`; `out_buff_enabled` stays high.
- DONE: `done`=1 for one cycle, then IDLE.
- All outputs except `busy` and `row_idx` are combinational decodes of state and handshake inputs. `row_idx` and the counters are registers.
- Boundaries:
  - `start` while busy: ignored, not queued.
  - `inbuf_valid` outside LOAD/STREAM: not consumed (`inbuf_ready`=0).
  - N=1: LOAD, STREAM and DRAIN each last one beat; FLUSH lasts 1 cycle.
  - Reset mid-tile: immediate return to IDLE. The partial tile is discarded and the next `start` restarts from LOAD.

## Timing
- Cycle 0 = `start` sampled in IDLE. With no stalls:
  - LOAD: cycles 1..N.
  - STREAM: N+1..2N.
  - FLUSH: 2N+1..2N+FLUSH_CYC.
  - DRAIN: the next N cycles.
  - `done`: the following cycle.
- Default N=4 latency: `done` at cycle 5N = 20.
- Each input stall cycle and each output backpressure cycle adds exactly one cycle.
- Beats are transferred only on posedge with valid&ready both high.
- `inbuf_ready` does not depend combinationally on `inbuf_valid`.

## Configuration
- `MMUL_SCHED_PERF_EN`, when defined, adds:
  - `perf_cycles` out, 32 bits: cycles from the LOAD entry through DONE inclusive, for the last completed tile.
  - `perf_stalls` out, 32 bits: count of LOAD/STREAM cycles with `inbuf_valid`=0 plus DRAIN cycles with feedback=0.
- Both counters saturate at all ones, clear at LOAD entry, reset to 0, and update on DONE.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Shared package `mmul_pkg`:
  - state encoding localparams (IDLE=0..DONE=5);
  - `clog2` helper;
  - default `N`.
- Sub-module `mmul_sched_cnt`: a loadable down counter with zero flag, used for the FLUSH count. `row_idx` is an up counter in the top level.

## Test plan
- Reset, N=4, `start` pulse, all handshakes always ready:
  - 4 `w_load`, then 4 `a_feed`, then 7 `a_zero`, then 4 `out_buff_enabled` rows 0..3;
  - `done` at cycle 20.
- `inbuf_valid` low for 3 cycles during STREAM row 2: `array_en`=0 for those 3 cycles; `done` at cycle 23.
- `out_buff_enable_feedback` low for 2 cycles on row 1: `row_idx` holds 1 for those cycles; `done` at cycle 22.
- `start` pulsed during FLUSH: ignored, and exactly one `done` occurs.
- `reset` asserted in DRAIN row 2:
  - all outputs are 0 in the same cycle;
  - next `start` gives a full tile, `done` at cycle 20.
- With `MMUL_SCHED_PERF_EN` and the 3-cycle input stall case: `perf_cycles`=23, `perf_stalls`=3.

Source files
------------

// File: rtl/mmul_pkg.sv
// Shared definitions for the systolic-array tile scheduler.
//   - MMUL_N_DEFAULT : default array dimension
//   - ST_* localparams : FSM state encoding (IDLE=0 .. DONE=5)
//   - sched_state_e    : enum built on that encoding
//   - clog2()          : ceil(log2(v)), never less than 1, for index widths
//   - sat_inc32()      : 32-bit increment that sticks at all ones
package mmul_pkg;

    localparam int MMUL_N_DEFAULT = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_FLUSH  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_STREAM = ST_STREAM,
        S_FLUSH  = ST_FLUSH,
        S_DRAIN  = ST_DRAIN,
        S_DONE   = ST_DONE
    } sched_state_e;

    // Width needed to index 'value' items; a 1-entry range still gets 1 bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mmul_tile_sched_if.sv
// Handshake/control bundle between the tile scheduler and its neighbours
// (input buffer, systolic array, output adapter).
//   master : the scheduler (drives busy/done, inbuf_ready, array controls,
//            row_idx, out_buff_enabled; samples start, inbuf_valid,
//            out_buff_enable_feedback)
//   slave  : the surrounding logic, opposite directions
// With MMUL_SCHED_PERF_EN defined the bundle also carries perf_cycles and
// perf_stalls (32-bit scheduler outputs).
interface mmul_tile_sched_if
    import mmul_pkg::*;
#(
    parameter int N = MMUL_N_DEFAULT
);
    localparam int RW = clog2(N);

    logic          start;
    logic          busy;
    logic          done;
    logic          inbuf_valid;
    logic          inbuf_ready;
    logic          w_load;
    logic          a_feed;
    logic          a_zero;
    logic          array_en;
    logic [RW-1:0] row_idx;
    logic          out_buff_enabled;
    logic          out_buff_enable_feedback;
`ifdef MMUL_SCHED_PERF_EN
    logic [31:0]   perf_cycles;
    logic [31:0]   perf_stalls;

    modport master (
        input  start, inbuf_valid, out_buff_enable_feedback,
        output busy, done, inbuf_ready, w_load, a_feed, a_zero, array_en,
        output row_idx, out_buff_enabled, perf_cycles, perf_stalls
    );
    modport slave (
        output start, inbuf_valid, out_buff_enable_feedback,
        input  busy, done, inbuf_ready, w_load, a_feed, a_zero, array_en,
        input  row_idx, out_buff_enabled, perf_cycles, perf_stalls
    );
`else
    modport master (
        input  start, inbuf_valid, out_buff_enable_feedback,
        output busy, done, inbuf_ready, w_load, a_feed, a_zero, array_en,
        output row_idx, out_buff_enabled
    );
    modport slave (
        output start, inbuf_valid, out_buff_enable_feedback,
        input  busy, done, inbuf_ready, w_load, a_feed, a_zero, array_en,
        input  row_idx, out_buff_enabled
    );
`endif

endinterface

// File: rtl/mmul_sched_cnt.sv
// Loadable down counter with zero flag (times the array flush).
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over dec)
//   dec        : decrement by one; holds at zero
//   count      : current value
//   zero       : count == 0
module mmul_sched_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/mmul_tile_sched.sv
// Tile scheduler for the N x N systolic matrix multiplier.
// Per start: load N weight rows, stream N activation rows, flush the array
// for FLUSH_CYC cycles, then drain N result rows under output backpressure.
// Ports:
//   clk   : single clock, posedge
//   reset : asynchronous, active-high; forces IDLE and all outputs low
//   bus   : mmul_tile_sched_if.master (start/busy/done, input buffer
//           handshake, array enables, row_idx, output handshake)
// Optional: defining MMUL_SCHED_PERF_EN adds perf_cycles/perf_stalls on bus.
// busy and row_idx are registered; every other output is a combinational
// decode of the state and the handshake inputs.
module mmul_tile_sched
    import mmul_pkg::*;
#(
    parameter int N         = MMUL_N_DEFAULT,
    parameter int FLUSH_CYC = 2*N-1
) (
    input  logic              clk,
    input  logic              reset,
    mmul_tile_sched_if.master bus
);

    localparam int              RW       = clog2(N);
    localparam int              CW       = clog2(FLUSH_CYC + 1);
    localparam logic [RW-1:0]   ROW_LAST = RW'(N - 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(FLUSH_CYC);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    sched_state_e  state_q, state_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic          busy_q, busy_d;

    logic          inbuf_ready;
    logic          w_load;
    logic          a_feed;
    logic          a_zero;
    logic          array_en;
    logic          out_buff_enabled;
    logic          done;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] flush_cnt;
    logic          flush_zero;

    mmul_sched_cnt #(
        .W(CW)
    ) u_flush_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .count    (flush_cnt),
        .zero     (flush_zero)
    );

    always_comb begin
        state_d          = state_q;
        row_idx_d        = row_idx_q;
        inbuf_ready      = 1'b0;
        w_load           = 1'b0;
        a_feed           = 1'b0;
        a_zero           = 1'b0;
        array_en         = 1'b0;
        out_buff_enabled = 1'b0;
        done             = 1'b0;
        cnt_load         = 1'b0;
        cnt_dec          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    row_idx_d = '0;
                end
            end

            S_LOAD: begin
                // Ready is a pure state decode; valid only qualifies the beat.
                inbuf_ready = 1'b1;
                if (bus.inbuf_valid) begin
                    w_load = 1'b1;
                    if (row_idx_q == ROW_LAST) begin
                        row_idx_d = '0;
                        state_d   = S_STREAM;
                    end else begin
                        row_idx_d = row_idx_q + RW'(1);
                    end
                end
            end

            S_STREAM: begin
                inbuf_ready = 1'b1;
                // The array only steps on a real activation beat, so an
                // input stall freezes it rather than injecting garbage.
                if (bus.inbuf_valid) begin
                    a_feed   = 1'b1;
                    array_en = 1'b1;
                    if (row_idx_q == ROW_LAST) begin
                        row_idx_d = '0;
                        state_d   = S_FLUSH;
                        cnt_load  = 1'b1;
                    end else begin
                        row_idx_d = row_idx_q + RW'(1);
                    end
                end
            end

            S_FLUSH: begin
                a_zero   = 1'b1;
                array_en = 1'b1;
                cnt_dec  = 1'b1;
                // Leaving on count==1 gives exactly FLUSH_CYC flush cycles;
                // the zero flag guards against a degenerate zero-length load.
                if ((flush_cnt == CNT_ONE) || flush_zero) begin
                    row_idx_d = '0;
                    state_d   = S_DRAIN;
                end
            end

            S_DRAIN: begin
                out_buff_enabled = 1'b1;
                if (bus.out_buff_enable_feedback) begin
                    if (row_idx_q == ROW_LAST) begin
                        row_idx_d = '0;
                        state_d   = S_DONE;
                    end else begin
                        row_idx_d = row_idx_q + RW'(1);
                    end
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                row_idx_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            row_idx_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done;
    assign bus.inbuf_ready      = inbuf_ready;
    assign bus.w_load           = w_load;
    assign bus.a_feed           = a_feed;
    assign bus.a_zero           = a_zero;
    assign bus.array_en         = array_en;
    assign bus.row_idx          = row_idx_q;
    assign bus.out_buff_enabled = out_buff_enabled;

`ifdef MMUL_SCHED_PERF_EN
    // Running counters restart at LOAD entry; the visible values only change
    // in DONE so they always describe the last completed tile.
    logic [31:0] run_cyc_q, run_cyc_d;
    logic [31:0] run_stall_q, run_stall_d;
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        run_cyc_d     = run_cyc_q;
        run_stall_d   = run_stall_q;
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;

        if (state_q == S_IDLE) begin
            if (bus.start) begin
                run_cyc_d   = '0;
                run_stall_d = '0;
            end
        end else begin
            run_cyc_d = sat_inc32(run_cyc_q);
            if ((((state_q == S_LOAD) || (state_q == S_STREAM)) && !bus.inbuf_valid) ||
                ((state_q == S_DRAIN) && !bus.out_buff_enable_feedback)) begin
                run_stall_d = sat_inc32(run_stall_q);
            end
            if (state_q == S_DONE) begin
                // The DONE cycle itself is part of the tile.
                perf_cycles_d = sat_inc32(run_cyc_q);
                perf_stalls_d = run_stall_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cyc_q     <= '0;
            run_stall_q   <= '0;
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            run_cyc_q     <= run_cyc_d;
            run_stall_q   <= run_stall_d;
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign bus.perf_cycles = perf_cycles_q;
    assign bus.perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_mmul_tile_sched.sv
// Directed bench for mmul_tile_sched at N=4 (FLUSH_CYC=7).
// Cycle numbering: cycle 0 is the cycle whose closing edge samples start;
// cycle k is the interval after the k-th following edge. Nominal phases:
// LOAD 1..4, STREAM 5..8, FLUSH 9..15, DRAIN 16..19, DONE 20.
module tb_mmul_tile_sched;
    import mmul_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mmul_tile_sched_if #(.N(4)) bus ();

    mmul_tile_sched #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"},             32'(bus.busy), 0);
        check({tag, ".done"},             32'(bus.done), 0);
        check({tag, ".inbuf_ready"},      32'(bus.inbuf_ready), 0);
        check({tag, ".w_load"},           32'(bus.w_load), 0);
        check({tag, ".a_feed"},           32'(bus.a_feed), 0);
        check({tag, ".a_zero"},           32'(bus.a_zero), 0);
        check({tag, ".array_en"},         32'(bus.array_en), 0);
        check({tag, ".row_idx"},          32'(bus.row_idx), 0);
        check({tag, ".out_buff_enabled"}, 32'(bus.out_buff_enabled), 0);
    endtask

    function automatic logic [31:0] in_win(input int c, input int lo, input int hi);
        return (c >= lo && c <= hi) ? 32'd1 : 32'd0;
    endfunction

    // Runs one tile. Input stall window [vlo,vhi], output backpressure
    // window [flo,fhi], extra start pulse at cycle start_at, reset at
    // cycle reset_at (-1 disables each). Prints one line per tile.
    task automatic run_tile(input string tag, input int exp_done,
                            input int vlo, input int vhi, input int flo, input int fhi,
                            input int start_at, input int reset_at, input bit phases);
        int c;
        int done_cyc;
        int n_done;
        int n_w;
        int n_af;
        int n_az;
        int n_acc;
        bit aborted;
        done_cyc = -1; n_done = 0; n_w = 0; n_af = 0; n_az = 0; n_acc = 0;
        aborted  = 1'b0;

        bus.start = 1'b1;
        @(posedge clk);
        c = 1;
        while (c <= 60) begin
            #1;
            bus.start                    = (c == start_at);
            bus.inbuf_valid              = (in_win(c, vlo, vhi) == 0);
            bus.out_buff_enable_feedback = (in_win(c, flo, fhi) == 0);
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                check_all_zero({tag, ".reset"});
                #1;
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end
            #1;
            if (bus.w_load) begin
                check({tag, ".w_row"}, 32'(bus.row_idx), n_w); n_w++;
            end
            if (bus.a_feed) begin
                check({tag, ".a_row"}, 32'(bus.row_idx), n_af); n_af++;
            end
            if (bus.a_zero) n_az++;
            if (bus.out_buff_enabled && bus.out_buff_enable_feedback) begin
                check({tag, ".out_row"}, 32'(bus.row_idx), n_acc); n_acc++;
            end
            if (in_win(c, vlo, vhi) != 0) begin
                check({tag, ".stall_array_en"}, 32'(bus.array_en), 0);
                check({tag, ".stall_ready"},    32'(bus.inbuf_ready), 1);
            end
            if (in_win(c, flo, fhi) != 0) begin
                check({tag, ".bp_row_hold"}, 32'(bus.row_idx), 1);
                check({tag, ".bp_out_en"},   32'(bus.out_buff_enabled), 1);
            end
            if (phases && c <= 21) begin
                check({tag, ".ph_w_load"},   32'(bus.w_load),      in_win(c, 1, 4));
                check({tag, ".ph_a_feed"},   32'(bus.a_feed),      in_win(c, 5, 8));
                check({tag, ".ph_a_zero"},   32'(bus.a_zero),      in_win(c, 9, 15));
                check({tag, ".ph_array_en"}, 32'(bus.array_en),    in_win(c, 5, 15));
                check({tag, ".ph_ready"},    32'(bus.inbuf_ready), in_win(c, 1, 8));
                check({tag, ".ph_out_en"},   32'(bus.out_buff_enabled), in_win(c, 16, 19));
                check({tag, ".ph_busy"},     32'(bus.busy),        in_win(c, 1, 20));
                check({tag, ".ph_done"},     32'(bus.done),        in_win(c, 20, 20));
                if (c >= 16 && c <= 19) check({tag, ".ph_row"}, 32'(bus.row_idx), c - 16);
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c > done_cyc) begin
                check({tag, ".idle_busy"}, 32'(bus.busy), 0);
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk);
            c++;
        end
        bus.start = 1'b0;
        bus.inbuf_valid = 1'b1;
        bus.out_buff_enable_feedback = 1'b1;

        if (!aborted) begin
            check({tag, ".done_cycle"}, done_cyc, exp_done);
            check({tag, ".done_count"}, n_done, 1);
            check({tag, ".n_w_load"},   n_w, 4);
            check({tag, ".n_a_feed"},   n_af, 4);
            check({tag, ".n_a_zero"},   n_az, 7);
            check({tag, ".n_out_rows"}, n_acc, 4);
        end
        $display("tile %s: done_cycle=%0d w=%0d a=%0d z=%0d out=%0d aborted=%0d",
                 tag, done_cyc, n_w, n_af, n_az, n_acc, aborted);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.start = 1'b0;
        bus.inbuf_valid = 1'b1;
        bus.out_buff_enable_feedback = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("por");
`ifdef MMUL_SCHED_PERF_EN
        check("por.perf_cycles", bus.perf_cycles, 0);
        check("por.perf_stalls", bus.perf_stalls, 0);
`endif
        reset = 1'b0;
        @(posedge clk);
        #1;
        // A valid row while idle must not be consumed.
        check("idle.inbuf_ready", 32'(bus.inbuf_ready), 0);
        check("idle.busy",        32'(bus.busy), 0);

        run_tile("nominal", 20, -1, -1, -1, -1, -1, -1, 1'b1);
`ifdef MMUL_SCHED_PERF_EN
        check("nominal.perf_cycles", bus.perf_cycles, 20);
        check("nominal.perf_stalls", bus.perf_stalls, 0);
`endif
        run_tile("in_stall", 23, 7, 9, -1, -1, -1, -1, 1'b0);
`ifdef MMUL_SCHED_PERF_EN
        check("in_stall.perf_cycles", bus.perf_cycles, 23);
        check("in_stall.perf_stalls", bus.perf_stalls, 3);
`endif
        run_tile("out_stall", 22, -1, -1, 17, 18, -1, -1, 1'b0);
`ifdef MMUL_SCHED_PERF_EN
        check("out_stall.perf_cycles", bus.perf_cycles, 22);
        check("out_stall.perf_stalls", bus.perf_stalls, 2);
`endif
        run_tile("start_in_flush", 20, -1, -1, -1, -1, 10, -1, 1'b0);
        run_tile("reset_drain", 0, -1, -1, -1, -1, -1, 18, 1'b0);
        run_tile("after_reset", 20, -1, -1, -1, -1, -1, -1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
